// File: rtl/mem_init_seq.sv
// Power-on / requested RAM clear sequencer: sweeps every RAM address with a fill
// pattern, holds the core in reset for HOLD_CYC cycles, then releases it.
module mem_init_seq #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  FILL     = '1,
    parameter int                 MODE     = 0,
    parameter int                 PAGE_W   = 7,
    parameter int                 HOLD_CYC = 16
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_we_o,
    output logic              sys_reset_o,
    output logic              busy_o,
    output logic              done_o
);

    // state    | meaning
    // ST_CLEAR | writing fill data, one address per accepted write
    // ST_HOLD  | RAM cleared, core still held in reset by hold counter
    // ST_RUN   | core released; done pulses on the first cycle
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int                 CNT_W     = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   addr_lo;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        mem_we_o    = 1'b0;
        busy_o      = 1'b0;
        sys_reset_o = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                mem_we_o = 1'b1;
                busy_o   = 1'b1;
                if (mem_ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_HOLD;
                        addr_d  = '0;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                sys_reset_o = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // A request restarts the sweep from scratch, overriding any transition above.
        if (req_i) begin
            state_d = ST_CLEAR;
            addr_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    generate
        if (ADDR_W >= DATA_W) begin : g_addr_trunc
            assign addr_lo = addr_q[DATA_W-1:0];
        end else begin : g_addr_zext
            assign addr_lo = {{(DATA_W - ADDR_W){1'b0}}, addr_q};
        end
    endgenerate

    always_comb begin
        mem_data_o = FILL;
        if (MODE == 1) begin
            mem_data_o = addr_q[PAGE_W] ? ~FILL : FILL;
        end else if (MODE == 2) begin
            mem_data_o = FILL ^ addr_lo;
        end
    end

    assign mem_addr_o = addr_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_mem_init_seq.sv
// Bench for mem_init_seq: three small instances (constant, page-alternating and
// address-derived fill) share stimulus and are compared against a counting model.
module tb_mem_init_seq;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int HOLD = 3;
    localparam int N    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          rdy;
    logic [AW-1:0] mem_addr [3];
    logic [DW-1:0] mem_data [3];
    logic          mem_we   [3];
    logic          sys_rst  [3];
    logic          busy     [3];
    logic          done     [3];

    int checks   = 0;
    int failures = 0;

    // behavioural model: position in the sweep, remaining hold cycles, released flag
    bit m_clear;
    int m_addr;
    int m_hold;
    bit m_run;
    bit m_done;

    always #5 clk = ~clk;

    mem_init_seq #(.ADDR_W(AW), .DATA_W(DW), .FILL(8'hFF), .MODE(0), .PAGE_W(2), .HOLD_CYC(HOLD)) u_m0 (
        .clk_sys_i(clk), .reset_i(reset), .req_i(req), .mem_ready_i(rdy),
        .mem_addr_o(mem_addr[0]), .mem_data_o(mem_data[0]), .mem_we_o(mem_we[0]),
        .sys_reset_o(sys_rst[0]), .busy_o(busy[0]), .done_o(done[0]));

    mem_init_seq #(.ADDR_W(AW), .DATA_W(DW), .FILL(8'hFF), .MODE(1), .PAGE_W(2), .HOLD_CYC(HOLD)) u_m1 (
        .clk_sys_i(clk), .reset_i(reset), .req_i(req), .mem_ready_i(rdy),
        .mem_addr_o(mem_addr[1]), .mem_data_o(mem_data[1]), .mem_we_o(mem_we[1]),
        .sys_reset_o(sys_rst[1]), .busy_o(busy[1]), .done_o(done[1]));

    mem_init_seq #(.ADDR_W(AW), .DATA_W(DW), .FILL(8'h0F), .MODE(2), .PAGE_W(2), .HOLD_CYC(HOLD)) u_m2 (
        .clk_sys_i(clk), .reset_i(reset), .req_i(req), .mem_ready_i(rdy),
        .mem_addr_o(mem_addr[2]), .mem_data_o(mem_data[2]), .mem_we_o(mem_we[2]),
        .sys_reset_o(sys_rst[2]), .busy_o(busy[2]), .done_o(done[2]));

    function automatic logic [7:0] exp_data(input int k, input int a);
        logic [7:0] a8;
        a8 = 8'(a);
        if (k == 1) return (((a / 4) % 2) == 1) ? 8'h00 : 8'hFF;
        if (k == 2) return 8'h0F ^ a8;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        m_clear = 1'b1; m_addr = 0; m_hold = 0; m_run = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic y);
        m_done = 1'b0;
        if (r) begin
            m_clear = 1'b1; m_run = 1'b0; m_addr = 0; m_hold = 0;
        end else if (m_clear) begin
            if (y) begin
                if (m_addr == N - 1) begin
                    m_clear = 1'b0; m_addr = 0; m_hold = HOLD;
                end else begin
                    m_addr = m_addr + 1;
                end
            end
        end else if (!m_run) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin
                m_run = 1'b1; m_done = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic y);
        req = r;
        rdy = y;
        @(posedge clk);
        model_edge(r, y);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = 1'b0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sys_rst[k] !== 1'b1 || busy[k] !== 1'b1 || mem_we[k] !== 1'b1 || done[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl inst%0d: got sr=%b busy=%b we=%b done=%b want 1 1 1 0",
                         k, sys_rst[k], busy[k], mem_we[k], done[k]);
            end
            checks++;
            if (mem_addr[k] !== 4'd0) begin
                failures++;
                $display("FAIL reset_addr inst%0d: got %0d want 0", k, mem_addr[k]);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_clear();
        int edges = 0, writes = 0, dones = 0;
        bit fell = 0;
        apply_reset();
        while (!fell && edges < 60) begin
            if (mem_we[0]) begin
                checks++;
                if (writes >= N || mem_addr[0] !== 4'(writes) || mem_data[0] !== 8'hFF) begin
                    failures++;
                    $display("FAIL basic_write #%0d: got addr=%0d data=%h want addr=%0d data=ff",
                             writes, mem_addr[0], mem_data[0], writes);
                end
                writes++;
            end
            step(1'b0, 1'b1);
            edges++;
            if (done[0]) dones++;
            if (!sys_rst[0]) fell = 1;
        end
        checks++;
        if (writes != N) begin
            failures++;
            $display("FAIL basic_writes: got %0d want %0d", writes, N);
        end
        checks++;
        if (edges != N + HOLD || !fell) begin
            failures++;
            $display("FAIL basic_release_time: got %0d cycles (released=%0d) want %0d", edges, fell, N + HOLD);
        end
        repeat (3) begin
            step(1'b0, 1'b1);
            if (done[0]) dones++;
            checks++;
            if (sys_rst[0] !== 1'b0 || mem_we[0] !== 1'b0 || busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL run_stable: got sr=%b we=%b busy=%b want 0 0 0", sys_rst[0], mem_we[0], busy[0]);
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL done_pulses: got %0d want 1", dones);
        end
    endtask

    task automatic test_stall();
        int cyc = 0, nexp = 0, writes = 0;
        logic y;
        logic [AW-1:0] prev;
        apply_reset();
        while (busy[0] && cyc < 100) begin
            y = (cyc % 2 == 1) ? 1'b0 : 1'b1;
            prev = mem_addr[0];
            if (mem_we[0] && y) begin
                checks++;
                if (mem_addr[0] !== 4'(nexp)) begin
                    failures++;
                    $display("FAIL stall_order: got addr=%0d want %0d", mem_addr[0], nexp);
                end
                nexp++;
                writes++;
            end
            step(1'b0, y);
            if (!y) begin
                checks++;
                if (mem_addr[0] !== prev) begin
                    failures++;
                    $display("FAIL stall_hold: got addr=%0d want %0d", mem_addr[0], prev);
                end
            end
            cyc++;
        end
        checks++;
        if (writes != N || sys_rst[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL stall_writes: got writes=%0d sr=%b busy=%b want %0d 1 0", writes, sys_rst[0], busy[0], N);
        end
    endtask

    task automatic test_mode1_pattern();
        apply_reset();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem_addr[1] !== 4'(i) || mem_data[1] !== exp_data(1, i)) begin
                failures++;
                $display("FAIL mode1_data @%0d: got addr=%0d data=%h want data=%h", i, mem_addr[1], mem_data[1], exp_data(1, i));
            end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_mode2_data();
        apply_reset();
        repeat (5) step(1'b0, 1'b1);
        checks++;
        if (mem_addr[2] !== 4'd5 || mem_data[2] !== 8'h0A) begin
            failures++;
            $display("FAIL mode2_addr5: got addr=%0d data=%h want addr=5 data=0a", mem_addr[2], mem_data[2]);
        end
        for (int i = 5; i < N; i++) begin
            checks++;
            if (mem_data[2] !== exp_data(2, i)) begin
                failures++;
                $display("FAIL mode2_data @%0d: got %h want %h", i, mem_data[2], exp_data(2, i));
            end
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_req_restart();
        int edges = 0;
        bit fell = 0;
        apply_reset();
        repeat (9) step(1'b0, 1'b1);
        checks++;
        if (mem_addr[0] !== 4'd9) begin
            failures++;
            $display("FAIL req_setup: got addr=%0d want 9", mem_addr[0]);
        end
        step(1'b1, 1'b1);
        checks++;
        if (mem_addr[0] !== 4'd0 || sys_rst[0] !== 1'b1 || busy[0] !== 1'b1 || mem_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL req_clear: got addr=%0d sr=%b busy=%b we=%b want 0 1 1 1", mem_addr[0], sys_rst[0], busy[0], mem_we[0]);
        end
        repeat (N + 1) step(1'b0, 1'b1);
        checks++;
        if (sys_rst[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL req_hold_setup: got sr=%b busy=%b want 1 0", sys_rst[0], busy[0]);
        end
        step(1'b1, 1'b1);
        checks++;
        if (mem_addr[0] !== 4'd0 || sys_rst[0] !== 1'b1 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL req_hold: got addr=%0d sr=%b busy=%b want 0 1 1", mem_addr[0], sys_rst[0], busy[0]);
        end
        while (!fell && edges < 60) begin
            step(1'b0, 1'b1);
            edges++;
            if (!sys_rst[0]) fell = 1;
        end
        checks++;
        if (edges != N + HOLD || !fell) begin
            failures++;
            $display("FAIL req_release_time: got %0d cycles (released=%0d) want %0d", edges, fell, N + HOLD);
        end
    endtask

    task automatic test_async_reset_hold();
        apply_reset();
        repeat (N + 1) step(1'b0, 1'b1);
        checks++;
        if (sys_rst[0] !== 1'b1 || busy[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_setup: got sr=%b busy=%b we=%b want 1 0 0", sys_rst[0], busy[0], mem_we[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sys_rst[0] !== 1'b1 || busy[0] !== 1'b1 || mem_addr[0] !== 4'd0 || mem_we[0] !== 1'b1 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got sr=%b busy=%b addr=%0d we=%b done=%b want 1 1 0 1 0",
                     sys_rst[0], busy[0], mem_addr[0], mem_we[0], done[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic r, y;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 63) == 0);
            y = ($urandom_range(0, 3) != 0);
            step(r, y);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (mem_addr[k] !== 4'(m_addr) || mem_data[k] !== exp_data(k, m_addr)) begin
                    failures++;
                    $display("FAIL rand_addr_data c%0d inst%0d: got %0d/%h want %0d/%h",
                             c, k, mem_addr[k], mem_data[k], m_addr, exp_data(k, m_addr));
                end
                checks++;
                if (mem_we[k] !== m_clear || busy[k] !== m_clear || sys_rst[k] !== !m_run || done[k] !== m_done) begin
                    failures++;
                    $display("FAIL rand_ctrl c%0d inst%0d: got we=%b busy=%b sr=%b done=%b want %b %b %b %b",
                             c, k, mem_we[k], busy[k], sys_rst[k], done[k], m_clear, m_clear, !m_run, m_done);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        rdy   = 1'b1;
        test_reset();
        test_basic_clear();
        test_stall();
        test_mode1_pattern();
        test_mode2_data();
        test_req_restart();
        test_async_reset_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_init_seq.md
MEM_INIT_SEQ -- requirements
Module: mem_init_seq

Interface
REQ-001 Parameter ADDR_W, default 16: RAM address width; the block clears 2^ADDR_W locations.
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 Parameter FILL, default all-ones (DATA_W bits): base fill value.
REQ-004 Parameter MODE, default 0: fill mode; 0=constant FILL, 1=page-alternating, 2=address-derived.
REQ-005 Parameter PAGE_W, default 7: page size, 2^PAGE_W locations, used by MODE 1; PAGE_W < ADDR_W.
REQ-006 Parameter HOLD_CYC, default 16: number of cycles sys_reset is held after clearing completes; must be >= 1.
REQ-007 clk_sys  in  1  system clock; all logic is on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 req  in  1  synchronous reset request (OSD, button, core); level-sensitive.
REQ-010 mem_ready  in  1  RAM port accepts the current write this cycle.
REQ-011 mem_addr  out  ADDR_W  clear address.
REQ-012 mem_data  out  DATA_W  fill data for mem_addr.
REQ-013 mem_we  out  1  write strobe; asserted only during CLEAR.
REQ-014 sys_reset  out  1  reset to the core; high in CLEAR and HOLD.
REQ-015 busy  out  1  high while in CLEAR.
REQ-016 done  out  1  one-cycle pulse on entry to RUN.

Function
REQ-017 The state machine SHALL have three states: CLEAR, HOLD and RUN.
REQ-018 CLEAR behaviour:
- mem_we=1, busy=1, sys_reset=1.
- A write is accepted on a cycle where mem_we & mem_ready.
- mem_addr SHALL increment by 1 only on an accepted write.
- mem_addr and mem_data SHALL stay stable while mem_ready=0.
REQ-019 CLEAR to HOLD: on the accepted write at mem_addr = 2^ADDR_W-1. In the same cycle, mem_addr wraps to 0 and the hold counter loads HOLD_CYC-1.
REQ-020 HOLD behaviour:
- mem_we=0, busy=0, sys_reset=1.
- The counter decrements once per cycle.
- At counter=0 the next state is RUN.
REQ-021 RUN behaviour: sys_reset=0, mem_we=0, busy=0; done=1 only on the first RUN cycle.
REQ-022 req=1 in any state SHALL force CLEAR on the next edge with mem_addr=0, discarding progress. This applies mid-CLEAR and mid-HOLD.
REQ-023 While req is held high, the machine SHALL stay in CLEAR at mem_addr=0 with mem_we=1. A write accepted while req=1 does not advance mem_addr.
REQ-024 If req and the final accepted write coincide, req wins: the state stays CLEAR and mem_addr=0.
REQ-025 mem_data SHALL be a combinational function of mem_addr:
- MODE 0: FILL.
- MODE 1: FILL when mem_addr[PAGE_W]=0, else ~FILL.
- MODE 2: FILL XOR mem_addr[DATA_W-1:0], with the address zero-extended if ADDR_W < DATA_W.
REQ-026 Total cycles from CLEAR entry to the first sys_reset=0, with mem_ready tied high, SHALL be exactly 2^ADDR_W + HOLD_CYC.
REQ-027 Counter widths SHALL hold their full range with no overflow. The hold counter is at least clog2(HOLD_CYC+1) bits.

Reset
REQ-028 While reset=1, outputs SHALL be:
- state=CLEAR, mem_addr=0, hold counter=0.
- sys_reset=1, busy=1, mem_we=1, done=0.
REQ-029 Entry into CLEAR is asynchronous on assertion of reset. Release is taken on the first clk_sys edge with reset=0, and clearing begins at address 0.

Verification
REQ-030 Scenario: ADDR_W=4, HOLD_CYC=3, mem_ready=1; release reset. Required: 16 writes to addresses 0..15 of 0xFF, then sys_reset falls exactly 19 cycles after release, with a single done pulse.
REQ-031 Scenario: ADDR_W=4, mem_ready low on every odd cycle. Required: 16 distinct addresses written, each exactly once, in order, with no address skipped while stalled.
REQ-032 Scenario: MODE=1, PAGE_W=2, ADDR_W=4, FILL=0xFF. Required: data pattern FF×4, 00×4, FF×4, 00×4.
REQ-033 Scenario: MODE=2, FILL=0x0F, ADDR_W=4. Required: address 5 receives 0x0A.
REQ-034 Scenario: req pulsed for one cycle at address 9 during CLEAR, and again in the 2nd HOLD cycle. Required: each time the next mem_addr is 0 and sys_reset stays high throughout; completion occurs a full 2^ADDR_W+HOLD_CYC cycles after the last req.
REQ-035 Scenario: async reset asserted mid-HOLD, between clock edges. Required: sys_reset=1, busy=1, mem_addr=0 immediately, before the next edge.
